// File: rtl/uc_mem_responder.sv
// uc_mem_responder: byte RAM + GPIO target for the uC data bus with programmable wait states.
module uc_mem_responder #(
  parameter int          DEPTH         = 64,
  parameter int          WAIT_STATES   = 1,
  parameter logic [7:0]  GPIO_OUT_ADDR = 8'hFE,
  parameter logic [7:0]  GPIO_IN_ADDR  = 8'hFF
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] mem_addr,
  input  logic       mem_write_en,
  input  logic       mem_read_en,
  input  logic [7:0] mem_data,
  output logic [7:0] mem_rdata,
  output logic       mem_ready,
  output logic       mem_busy,
  input  logic [7:0] in_gpio,
  output logic [7:0] out_gpio
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t           state_q;
  logic [1:0]       rst_sync_q;
  logic             rst;
  logic [3:0]       cnt_q;
  logic [7:0]       addr_q, data_q, out_q;
  logic             we_q;
  logic [15:0]      sync_q;
  logic [DEPTH-1:0] flags_q;
  logic [7:0]       mem_q [DEPTH];
  logic             accept, in_ram, commit, ram_we;
  logic [AW-1:0]    idx;
  logic [7:0]       rd_val;
  // Reset asserts immediately but releases two clocks after arst drops.
  always_ff @(posedge clk or posedge arst)
    if (arst) rst_sync_q <= 2'b11;
    else      rst_sync_q <= {rst_sync_q[0], 1'b0};
  assign rst    = rst_sync_q[1];
  assign accept = state_q != S_WAIT && (mem_write_en || mem_read_en);
  assign in_ram = int'(addr_q) < DEPTH;
  assign idx    = addr_q[AW-1:0];
  assign commit = state_q == S_RESP && we_q;
  assign ram_we = commit && in_ram;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      out_q   <= '0;
      sync_q  <= '0;
      flags_q <= '0;
    end else begin
      sync_q <= {sync_q[7:0], in_gpio};
      if (accept) begin
        addr_q  <= mem_addr;
        data_q  <= mem_data;
        we_q    <= mem_write_en;
        cnt_q   <= 4'(WAIT_STATES);
        state_q <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_q <= S_RESP;
      end else if (state_q == S_RESP) state_q <= S_IDLE;
      if (commit && addr_q == GPIO_OUT_ADDR) out_q <= data_q;
      if (ram_we) flags_q[idx] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (ram_we) mem_q[idx] <= data_q;
  always_comb
    rd_val = we_q                                ? 8'h00 :
             addr_q == GPIO_OUT_ADDR             ? out_q :
             addr_q == GPIO_IN_ADDR              ? sync_q[15:8] :
             (in_ram && flags_q[idx])            ? mem_q[idx] : 8'h00;
  assign mem_rdata = state_q == S_RESP ? rd_val : 8'h00;
  assign mem_ready = state_q == S_RESP;
  assign mem_busy  = state_q != S_IDLE;
  assign out_gpio  = out_q;
endmodule

// File: tb/tb_uc_mem_responder.sv
// tb_uc_mem_responder: scoreboard bench for uc_mem_responder with default parameters.
module tb_uc_mem_responder;
  localparam int WS = 1;
  logic       clk = 0, arst = 1;
  logic [7:0] mem_addr = 0, mem_data = 0, in_gpio = 0;
  logic       mem_write_en = 0, mem_read_en = 0;
  logic [7:0] mem_rdata, out_gpio;
  logic       mem_ready, mem_busy;
  int         checks = 0, fails = 0;
  logic [7:0] exp_q [$];

  uc_mem_responder dut (
    .clk(clk), .arst(arst), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data(mem_data), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .in_gpio(in_gpio), .out_gpio(out_gpio)
  );

  always #5 clk = ~clk;

  // Every completion must match the oldest outstanding expectation.
  always @(negedge clk)
    if (mem_ready) begin
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: rdata=%h with nothing outstanding", mem_rdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_rdata !== e) begin
          fails++;
          $display("FAIL rdata: got %h expected %h", mem_rdata, e);
        end
      end
    end

  task automatic req(input logic [7:0] a, input logic w, input logic r, input logic [7:0] d,
                     input logic [7:0] exp_rd);
    int n = 0;
    @(negedge clk);
    mem_addr = a; mem_write_en = w; mem_read_en = r; mem_data = d;
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    mem_write_en = 0; mem_read_en = 0;
    while (!mem_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== WS || mem_busy !== 1'b1) begin
      fails++;
      $display("FAIL latency @%h: got %0d edges busy=%b expected %0d busy=1", a, n, mem_busy, WS);
    end
  endtask

  task automatic settle_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) arst = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1;
    settle_reset();
    checks++;
    if ({mem_ready, mem_busy, mem_rdata, out_gpio} !== 18'h0) begin
      fails++;
      $display("FAIL reset_state: got ready=%b busy=%b rdata=%h out=%h expected all 0",
               mem_ready, mem_busy, mem_rdata, out_gpio);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_addr = 8'h03; mem_data = 8'hA5; mem_write_en = 1;
    @(posedge clk); #1;
    mem_write_en = 0;
    checks++;
    if (mem_busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", mem_busy); end
    arst = 1; #1;
    checks++;
    if (mem_busy !== 1'b0 || mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b ready=%b expected 0 0", mem_busy, mem_ready);
    end
    settle_reset();
    req(8'h03, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic test_ram();
    req(8'h10, 1'b1, 1'b0, 8'h5A, 8'h00);
    req(8'h10, 1'b0, 1'b1, 8'h00, 8'h5A);
    req(8'h20, 1'b0, 1'b1, 8'h00, 8'h00);
    req(8'h3F, 1'b1, 1'b0, 8'hAA, 8'h00);
    req(8'h3F, 1'b0, 1'b1, 8'h00, 8'hAA);
    req(8'h10, 1'b0, 1'b1, 8'h00, 8'h5A);
  endtask

  task automatic test_gpio_out();
    req(8'hFE, 1'b1, 1'b0, 8'hC3, 8'h00);
    checks++;
    if (out_gpio !== 8'h00) begin fails++; $display("FAIL gpio_early: got %h expected 00", out_gpio); end
    @(posedge clk); #1;
    checks++;
    if (out_gpio !== 8'hC3) begin fails++; $display("FAIL gpio_out: got %h expected c3", out_gpio); end
    req(8'hFE, 1'b0, 1'b1, 8'h00, 8'hC3);
  endtask

  task automatic test_gpio_in();
    in_gpio = 8'h81;
    repeat (3) @(posedge clk);
    req(8'hFF, 1'b0, 1'b1, 8'h00, 8'h81);
    req(8'hFF, 1'b1, 1'b0, 8'h12, 8'h00);
    req(8'hFF, 1'b0, 1'b1, 8'h00, 8'h81);
    checks++;
    if (out_gpio !== 8'hC3) begin fails++; $display("FAIL gpio_in_write: out got %h expected c3", out_gpio); end
  endtask

  task automatic test_unmapped();
    req(8'h80, 1'b1, 1'b0, 8'h11, 8'h00);
    req(8'h80, 1'b0, 1'b1, 8'h00, 8'h00);
    req(8'h40, 1'b1, 1'b0, 8'hBB, 8'h00);
    req(8'h40, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic test_both_and_held();
    @(negedge clk);
    mem_addr = 8'h05; mem_data = 8'h77; mem_write_en = 1; mem_read_en = 1;
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    mem_read_en = 0; mem_data = 8'h99;
    @(posedge clk); #1;
    mem_write_en = 0;
    checks++;
    if (mem_ready !== 1'b1) begin fails++; $display("FAIL both_ready: got %b expected 1", mem_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (mem_busy !== 1'b0) begin fails++; $display("FAIL held_ignored: busy got %b expected 0", mem_busy); end
    req(8'h05, 1'b0, 1'b1, 8'h00, 8'h77);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_ram();
    test_gpio_out();
    test_gpio_in();
    test_unmapped();
    test_both_and_held();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL outstanding: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
